// File: rtl/sha256_blk_sched.sv
`default_nettype none
// ============================================================================
// Module   : sha256_blk_sched
// Brief    : Collects 16 message words into a 512-bit block, launches the
//            SHA-256 core (IV-init or chaining) and hands back the digest.
//            Optional block counter enabled by macro SHA_SCHED_BLKCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_blk_sched #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         w_valid,
   input  logic [31:0]  w_data,
   input  logic         w_last,
   output logic         w_ready,
   output logic         core_start,
   output logic         core_init,
   output logic [511:0] core_blk,
   input  logic         core_done,
   input  logic [255:0] core_hash,
   output logic         digest_valid,
   output logic [255:0] digest,
   input  logic         digest_ready,
   output logic         busy,
   output logic         err_ovf,
   output logic         err_tmo,
   output logic [15:0]  blk_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FILL   = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_OUT    = 3'd4;

   localparam int              C_TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [C_TW-1:0] C_TMO_LAST = C_TW'(TIMEOUT_CYC - 1);

   logic [2:0]      r_state;
   logic [3:0]      r_wcnt;
   logic            r_first_blk;
   logic            r_last_blk;
   logic [31:0]     r_slot [16];
   logic [255:0]    r_digest;
   logic [C_TW-1:0] r_tmo;
   logic            r_err_ovf;
   logic            r_err_tmo;

   logic            w_accept;
   logic            w_tmo_run;
   logic            w_tmo_fire;
   logic [3:0]      w_slot;

   assign w_ready    = (r_state == S_IDLE) || (r_state == S_FILL);
   assign w_accept   = w_valid && w_ready;
   assign w_slot     = (r_state == S_IDLE) ? 4'd0 : r_wcnt;
   // Watchdog only ticks inside a partially filled block with no word offered
   assign w_tmo_run  = (r_state == S_FILL) && (r_wcnt != 4'd0) && !w_valid;
   assign w_tmo_fire = w_tmo_run && (r_tmo == C_TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wcnt      <= 4'd0;
         r_first_blk <= 1'b0;
         r_last_blk  <= 1'b0;
         r_digest    <= '0;
         r_tmo       <= '0;
         r_err_ovf   <= 1'b0;
         r_err_tmo   <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         if (w_valid && !w_ready) begin
            r_err_ovf <= 1'b1;
         end
         if (w_accept) begin
            r_slot[w_slot] <= w_data;
         end
         if (r_state != S_FILL) begin
            r_tmo <= '0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_wcnt      <= 4'd1;
                  r_first_blk <= 1'b1;
                  r_state     <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  r_wcnt <= r_wcnt + 4'd1;
                  r_tmo  <= '0;
                  if (r_wcnt == 4'd15) begin
                     r_last_blk <= w_last;
                     r_state    <= S_LAUNCH;
                  end
               end else if (w_tmo_fire) begin
                  r_err_tmo <= 1'b1;
                  r_wcnt    <= 4'd0;
                  r_tmo     <= '0;
                  r_state   <= S_IDLE;
               end else if (w_tmo_run) begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_LAUNCH: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  if (r_last_blk) begin
                     r_digest <= core_hash;
                     r_state  <= S_OUT;
                  end else begin
                     r_first_blk <= 1'b0;
                     r_wcnt      <= 4'd0;
                     r_state     <= S_FILL;
                  end
               end
            end
            S_OUT: begin
               if (digest_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < 16; g++) begin : g_pack
      assign core_blk[511-32*g -: 32] = r_slot[g];
   end

   assign core_start   = (r_state == S_LAUNCH);
   assign core_init    = core_start && r_first_blk;
   assign digest_valid = (r_state == S_OUT);
   assign digest       = r_digest;
   assign busy         = (r_state != S_IDLE);
   assign err_ovf      = r_err_ovf;
   assign err_tmo      = r_err_tmo;

`ifdef SHA_SCHED_BLKCNT_EN
   logic [15:0] r_blk_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blk_cnt <= 16'd0;
      end else if ((r_state == S_IDLE) && w_accept) begin
         r_blk_cnt <= 16'd0;
      end else if (r_state == S_LAUNCH) begin
         r_blk_cnt <= r_blk_cnt + 16'd1;
      end
   end

   assign blk_cnt = r_blk_cnt;
`else
   assign blk_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
